// File: rtl/latch_mon_pkg.sv
// Shared types and constants for the latch settle monitor.
package latch_mon_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_STALL  = 2'd3
  } state_t;

  localparam int TRANS_W = 16;

  // Reset values of the synchronised latch view: a closed latch holding Q=0.
  localparam logic EN_RST_VAL = 1'b0;
  localparam logic D_RST_VAL  = 1'b0;
  localparam logic Q_RST_VAL  = 1'b0;
  localparam logic QB_RST_VAL = 1'b1;

endpackage

// File: rtl/sync_chain.sv
// Single-bit flop chain used to bring an asynchronous latch signal into clk.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/latch_settle_monitor.sv
// Observes a clocked D-latch and measures how long Q takes to follow D while
// transparent; flags hold violations, settle timeouts and Q==Q_bar states.
module latch_settle_monitor
  import latch_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int MAX_SETTLE  = 32,
  parameter int HOLD_GRACE  = 2,
  parameter int ILLEGAL_TOL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lat_clk,
  input  logic               lat_d,
  input  logic               lat_q,
  input  logic               lat_qb,
  input  logic               clr_err,
  output logic [CNT_W-1:0]   settle_cycles,
  output logic               settle_valid,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_hold,
  output logic               err_illegal,
  output logic [TRANS_W-1:0] trans_cnt,
  output logic [1:0]         dbg_state
);

  localparam int GRACE_W = $clog2(HOLD_GRACE + 2);
  localparam int ILL_W   = $clog2(ILLEGAL_TOL + 2);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_SETTLE);
  localparam logic [GRACE_W-1:0] GRACE_MAX = GRACE_W'(HOLD_GRACE);
  localparam logic [ILL_W-1:0]   ILL_TOL   = ILL_W'(ILLEGAL_TOL);
  localparam logic [ILL_W-1:0]   ILL_SAT   = ILL_W'(ILLEGAL_TOL + 1);

  logic w_en_s, w_d_s, w_q_s, w_qb_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(EN_RST_VAL)) u_sync_en (
    .clk(clk), .rst(rst), .i_d(lat_clk), .o_q(w_en_s));
  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(D_RST_VAL)) u_sync_d (
    .clk(clk), .rst(rst), .i_d(lat_d), .o_q(w_d_s));
  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(Q_RST_VAL)) u_sync_q (
    .clk(clk), .rst(rst), .i_d(lat_q), .o_q(w_q_s));
  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(QB_RST_VAL)) u_sync_qb (
    .clk(clk), .rst(rst), .i_d(lat_qb), .o_q(w_qb_s));

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0]   r_settle_cycles, w_settle_val;
  logic               r_settle_valid, w_settle_load;
  logic               r_err_timeout, r_err_hold, r_err_illegal;
  logic               w_set_timeout, w_set_hold, w_set_illegal;
  logic               r_hold_ref, w_hold_ref_nxt;
  logic [GRACE_W-1:0] r_grace, w_grace_nxt;
  logic [ILL_W-1:0]   r_ill_cnt, w_ill_cnt_nxt;
  logic               r_q_prev;
  logic [TRANS_W-1:0] r_trans_cnt;
  logic               w_match, w_illegal, w_q_toggle;

  assign w_match    = (w_q_s == w_d_s);
  assign w_illegal  = (w_q_s == w_qb_s);
  assign w_q_toggle = (w_q_s != r_q_prev);
  assign w_cnt_inc  = r_cnt + 1'b1;

  // Measurement FSM. Dropping the enable always wins and silently discards
  // any in-flight measurement.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_settle_load = 1'b0;
    w_settle_val  = r_settle_cycles;
    w_set_timeout = 1'b0;
    if (!w_en_s) begin
      w_state_nxt = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_match) begin
            w_state_nxt   = ST_TRACK;
            w_settle_load = 1'b1;
            w_settle_val  = '0;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_TRACK: begin
          if (!w_match) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!w_match) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= MAX_CNT) begin
              w_set_timeout = 1'b1;
              w_state_nxt   = ST_STALL;
            end
          end else if (!w_illegal) begin
            w_state_nxt   = ST_TRACK;
            w_settle_load = 1'b1;
            w_settle_val  = r_cnt;
          end
        end
        ST_STALL: begin
          if (w_match) w_state_nxt = ST_TRACK;
        end
        default: w_state_nxt = ST_HOLD;
      endcase
    end
  end

  // Hold check: the reference follows Q through the grace window, then any
  // later Q change is flagged once and becomes the new reference.
  always_comb begin
    w_hold_ref_nxt = r_hold_ref;
    w_grace_nxt    = r_grace;
    w_set_hold     = 1'b0;
    if (r_state != ST_HOLD) begin
      if (w_state_nxt == ST_HOLD) begin
        w_hold_ref_nxt = w_q_s;
        w_grace_nxt    = '0;
      end
    end else if (r_grace < GRACE_MAX) begin
      w_hold_ref_nxt = w_q_s;
      w_grace_nxt    = r_grace + 1'b1;
    end else begin
      w_hold_ref_nxt = w_q_s;
      w_set_hold     = (w_q_s != r_hold_ref);
    end
  end

  always_comb begin
    w_ill_cnt_nxt = '0;
    w_set_illegal = 1'b0;
    if (w_illegal) begin
      w_ill_cnt_nxt = (r_ill_cnt >= ILL_SAT) ? ILL_SAT : r_ill_cnt + 1'b1;
      w_set_illegal = (w_ill_cnt_nxt > ILL_TOL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_HOLD;
      r_cnt           <= '0;
      r_settle_cycles <= '0;
      r_settle_valid  <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_err_hold      <= 1'b0;
      r_err_illegal   <= 1'b0;
      r_hold_ref      <= 1'b0;
      r_grace         <= '0;
      r_ill_cnt       <= '0;
      r_q_prev        <= Q_RST_VAL;
      r_trans_cnt     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_settle_valid <= w_settle_load;
      if (w_settle_load) r_settle_cycles <= w_settle_val;
      // A new error in the clearing cycle keeps the flag set.
      r_err_timeout  <= (r_err_timeout & ~clr_err) | w_set_timeout;
      r_err_hold     <= (r_err_hold    & ~clr_err) | w_set_hold;
      r_err_illegal  <= (r_err_illegal & ~clr_err) | w_set_illegal;
      r_hold_ref     <= w_hold_ref_nxt;
      r_grace        <= w_grace_nxt;
      r_ill_cnt      <= w_ill_cnt_nxt;
      r_q_prev       <= w_q_s;
      if (w_q_toggle && (r_trans_cnt != {TRANS_W{1'b1}})) begin
        r_trans_cnt <= r_trans_cnt + 1'b1;
      end
    end
  end

  // settle_valid is a one-cycle valid-only strobe with no back-pressure;
  // settle_cycles holds its value until the next strobe.
  assign settle_cycles = r_settle_cycles;
  assign settle_valid  = r_settle_valid;
  assign busy          = (r_state == ST_SETTLE);
  assign err_timeout   = r_err_timeout;
  assign err_hold      = r_err_hold;
  assign err_illegal   = r_err_illegal;
  assign trans_cnt     = r_trans_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_latch_settle_monitor.sv
// Directed bench for latch_settle_monitor with a settle-result scoreboard.
module tb_latch_settle_monitor;
  import latch_mon_pkg::*;

  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               lat_clk, lat_d, lat_q, lat_qb, clr_err;
  logic [CNT_W-1:0]   settle_cycles;
  logic               settle_valid, busy;
  logic               err_timeout, err_hold, err_illegal;
  logic [TRANS_W-1:0] trans_cnt;
  logic [1:0]         dbg_state;

  int total = 0;
  int bad   = 0;
  int busy_cycles = 0;
  int b0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_v;

  latch_settle_monitor #(
    .SYNC_STAGES(2), .CNT_W(CNT_W), .MAX_SETTLE(32), .HOLD_GRACE(2), .ILLEGAL_TOL(2)
  ) dut (
    .clk(clk), .rst(rst), .lat_clk(lat_clk), .lat_d(lat_d), .lat_q(lat_q),
    .lat_qb(lat_qb), .clr_err(clr_err), .settle_cycles(settle_cycles),
    .settle_valid(settle_valid), .busy(busy), .err_timeout(err_timeout),
    .err_hold(err_hold), .err_illegal(err_illegal), .trans_cnt(trans_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_q(input logic v);
    lat_q  = v;
    lat_qb = ~v;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (settle_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_settle_valid: got settle_cycles=%0d expected no pulse at %0t",
                   settle_cycles, $time);
        end else begin
          exp_v = exp_q.pop_front();
          check("settle_cycles", 32'(settle_cycles), 32'(exp_v));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; lat_clk = 1'b0; lat_d = 1'b0; lat_q = 1'b0; lat_qb = 1'b1; clr_err = 1'b0;

    // reset held while latch pins toggle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lat_q = ~lat_q;
      lat_d = ~lat_d;
      #1;
      check("reset_outputs", {1'b0, settle_cycles, settle_valid, busy, err_timeout,
            err_hold, err_illegal, trans_cnt, dbg_state}, 32'd0);
    end
    @(negedge clk);
    lat_q = 1'b0; lat_d = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(4);
    check("post_reset_state", 32'(dbg_state), 32'(ST_HOLD));
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_trans", 32'(trans_cnt), 32'd0);

    // enable with D==Q, then a 5-cycle settle
    exp_q.push_back(8'd0);
    lat_clk = 1'b1;
    tick(6);
    check("track_after_enable", 32'(dbg_state), 32'(ST_TRACK));
    exp_q.push_back(8'd5);
    b0 = busy_cycles;
    lat_d = 1'b1;
    tick(5);
    set_q(1'b1);
    tick(8);
    check("busy_cycles_settle5", 32'(busy_cycles - b0), 32'd5);
    check("track_after_settle", 32'(dbg_state), 32'(ST_TRACK));
    check("no_errors_settle", {29'd0, err_timeout, err_hold, err_illegal}, 32'd0);

    // Q stuck low against D=1: timeout after exactly 32 mismatch cycles
    set_q(1'b0);
    tick(33);
    check("timeout_not_yet", 32'(err_timeout), 32'd0);
    tick(1);
    check("timeout_set", 32'(err_timeout), 32'd1);
    check("stall_state", 32'(dbg_state), 32'(ST_STALL));
    check("stall_not_busy", 32'(busy), 32'd0);
    set_q(1'b1);
    tick(4);
    check("stall_to_track", 32'(dbg_state), 32'(ST_TRACK));

    // Q change one cycle after enable falls is inside the grace window
    lat_clk = 1'b0;
    tick(1);
    set_q(1'b0);
    tick(10);
    check("hold_grace_ok", 32'(err_hold), 32'd0);
    check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    exp_q.push_back(8'd0);
    lat_clk = 1'b1;
    lat_d   = 1'b0;
    tick(6);
    // Q change five cycles after enable falls is a violation
    lat_clk = 1'b0;
    tick(5);
    set_q(1'b1);
    tick(10);
    check("hold_violation", 32'(err_hold), 32'd1);
    pulse_clr();
    check("hold_cleared", 32'(err_hold), 32'd0);

    // Q==Q_bar for 2 cycles (tolerated), then 3 cycles (flagged)
    lat_qb = 1'b1;
    tick(2);
    lat_qb = 1'b0;
    tick(6);
    check("illegal_2_cycles", 32'(err_illegal), 32'd0);
    lat_qb = 1'b1;
    tick(3);
    lat_qb = 1'b0;
    tick(5);
    check("illegal_3_cycles", 32'(err_illegal), 32'd1);
    pulse_clr();
    check("illegal_cleared", 32'(err_illegal), 32'd0);
    lat_qb = 1'b1;
    tick(3);
    lat_qb = 1'b0;
    tick(1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(3);
    check("illegal_beats_clear", 32'(err_illegal), 32'd1);

    // fresh reset, 10 Q toggles, then reset in the middle of a settle
    rst = 1'b0; lat_clk = 1'b0; lat_d = 1'b0; set_q(1'b0);
    tick(2);
    rst = 1'b1;
    tick(4);
    check("trans_after_reset", 32'(trans_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      set_q(~lat_q);
      tick(2);
    end
    tick(4);
    check("trans_cnt_10", 32'(trans_cnt), 32'd10);
    lat_clk = 1'b1;
    lat_d   = 1'b1;
    tick(6);
    check("busy_mid_settle", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_trans", 32'(trans_cnt), 32'd0);
    check("abort_valid", 32'(settle_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_HOLD));
    tick(2);
    lat_clk = 1'b0;
    lat_d   = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(6);
    check("idle_after_abort", 32'(busy), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
